timer_tick_master: RTL and testbench



---
 rtl/timer_tick_master.sv | 174 +++++++++++++++++
 tb/tb_timer_tick_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tick_master.sv
// Avalon-MM initiator that programs the interval-timer slave, services its timeouts as
// one-cycle game ticks, and reads back 32-bit counter snapshots on request.
module timer_tick_master #(
   parameter logic [31:0] PERIOD     = 32'h0000C34F,
   parameter bit          CONTINUOUS = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic [31:0] cfg_period,
   input  logic        snap_req,
   output logic        tick,
   output logic [15:0] tick_count,
   output logic        busy,
   output logic [31:0] snap_value,
   output logic        snap_valid,
   output logic [3:0]  avm_address,
   output logic        avm_chipselect,
   output logic        avm_write_n,
   output logic [15:0] avm_writedata,
   input  logic [15:0] avm_readdata,
   input  logic        irq
);

   typedef enum logic [3:0] {
      IDLE, WR_P0, WR_P1, WR_P2, WR_P3, WR_CTRL, RUN, CLR, STOP_W,
      SNAP_W, SNAP_R0, SNAP_R1, SNAP_D
   } state_t;

   localparam logic [15:0] CTRL_RUN  = CONTINUOUS ? 16'h0007 : 16'h0005;
   localparam logic [15:0] CTRL_STOP = 16'h0008;

   state_t      state_q, state_d;
   logic [31:0] period_q, period_d;
   logic [15:0] tick_count_q, tick_count_d;
   logic        tick_q, tick_d;
   logic [31:0] snap_value_q, snap_value_d;
   logic        snap_valid_q, snap_valid_d;
   logic        stop_pend_q, stop_pend_d;
   logic        snap_pend_q, snap_pend_d;
   logic [3:0]  addr_q, addr_d;
   logic        cs_q, cs_d;
   logic        wn_q, wn_d;
   logic [15:0] wdata_q, wdata_d;

   always_comb begin
      state_d      = state_q;
      period_d     = period_q;
      tick_count_d = tick_count_q;
      tick_d       = 1'b0;
      snap_value_d = snap_value_q;
      snap_valid_d = 1'b0;
      stop_pend_d  = stop_pend_q;
      snap_pend_d  = snap_pend_q;

      // Requests that arrive while the FSM is busy elsewhere are remembered for RUN.
      if (state_q != IDLE && state_q != RUN && state_q != STOP_W) begin
         if (stop)
            stop_pend_d = 1'b1;
         if (snap_req)
            snap_pend_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            stop_pend_d = 1'b0;
            snap_pend_d = 1'b0;
            if (start) begin
               period_d     = (cfg_period == 32'd0) ? PERIOD : cfg_period;
               tick_count_d = 16'd0;
               state_d      = WR_P0;
            end
         end
         WR_P0:   state_d = WR_P1;
         WR_P1:   state_d = WR_P2;
         WR_P2:   state_d = WR_P3;
         WR_P3:   state_d = WR_CTRL;
         WR_CTRL: state_d = RUN;
         RUN: begin
            if (stop || stop_pend_q) begin
               stop_pend_d = 1'b0;
               snap_pend_d = 1'b0;
               state_d     = STOP_W;
            end else if (irq) begin
               tick_d       = 1'b1;
               tick_count_d = tick_count_q + 16'd1;
               if (snap_req)
                  snap_pend_d = 1'b1;
               state_d = CLR;
            end else if (snap_req || snap_pend_q) begin
               snap_pend_d = 1'b0;
               state_d     = SNAP_W;
            end
         end
         CLR:     state_d = CONTINUOUS ? RUN : IDLE;
         STOP_W:  state_d = IDLE;
         SNAP_W:  state_d = SNAP_R0;
         SNAP_R0: state_d = SNAP_R1;
         SNAP_R1: begin
            snap_value_d[15:0] = avm_readdata;
            state_d            = SNAP_D;
         end
         SNAP_D: begin
            snap_value_d[31:16] = avm_readdata;
            snap_valid_d        = 1'b1;
            state_d             = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs are derived from the next state so they are registered yet aligned with it.
   always_comb begin
      addr_d  = 4'd0;
      cs_d    = 1'b0;
      wn_d    = 1'b1;
      wdata_d = 16'd0;
      case (state_d)
         WR_P0:   begin addr_d = 4'd2; cs_d = 1'b1; wn_d = 1'b0; wdata_d = period_d[15:0];  end
         WR_P1:   begin addr_d = 4'd3; cs_d = 1'b1; wn_d = 1'b0; wdata_d = period_d[31:16]; end
         WR_P2:   begin addr_d = 4'd4; cs_d = 1'b1; wn_d = 1'b0; end
         WR_P3:   begin addr_d = 4'd5; cs_d = 1'b1; wn_d = 1'b0; end
         WR_CTRL: begin addr_d = 4'd1; cs_d = 1'b1; wn_d = 1'b0; wdata_d = CTRL_RUN;  end
         CLR:     begin addr_d = 4'd0; cs_d = 1'b1; wn_d = 1'b0; end
         STOP_W:  begin addr_d = 4'd1; cs_d = 1'b1; wn_d = 1'b0; wdata_d = CTRL_STOP; end
         SNAP_W:  begin addr_d = 4'd6; cs_d = 1'b1; wn_d = 1'b0; end
         SNAP_R0: begin addr_d = 4'd6; cs_d = 1'b1; end
         SNAP_R1: begin addr_d = 4'd7; cs_d = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         period_q     <= 32'd0;
         tick_count_q <= 16'd0;
         tick_q       <= 1'b0;
         snap_value_q <= 32'd0;
         snap_valid_q <= 1'b0;
         stop_pend_q  <= 1'b0;
         snap_pend_q  <= 1'b0;
         addr_q       <= 4'd0;
         cs_q         <= 1'b0;
         wn_q         <= 1'b1;
         wdata_q      <= 16'd0;
      end else begin
         state_q      <= state_d;
         period_q     <= period_d;
         tick_count_q <= tick_count_d;
         tick_q       <= tick_d;
         snap_value_q <= snap_value_d;
         snap_valid_q <= snap_valid_d;
         stop_pend_q  <= stop_pend_d;
         snap_pend_q  <= snap_pend_d;
         addr_q       <= addr_d;
         cs_q         <= cs_d;
         wn_q         <= wn_d;
         wdata_q      <= wdata_d;
      end
   end

   assign tick           = tick_q;
   assign tick_count     = tick_count_q;
   assign busy           = (state_q != IDLE);
   assign snap_value     = snap_value_q;
   assign snap_valid     = snap_valid_q;
   assign avm_address    = addr_q;
   assign avm_chipselect = cs_q;
   assign avm_write_n    = wn_q;
   assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_timer_tick_master.sv
// Directed bench for timer_tick_master: a behavioural timer slave, a bus scoreboard of
// expected transactions, and checks on tick, tick_count, busy and snapshots.
module tb_timer_tick_master;

   typedef struct {
      bit          we;
      logic [3:0]  addr;
      logic [15:0] data;
      int          cyc;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        snap_req = 1'b0;
   logic [31:0] cfg_period = 32'd0;
   logic        sel = 1'b0;
   logic [15:0] avm_readdata = 16'd0;

   logic        tick0, tick1, busy0, busy1, sv0, sv1, cs0, cs1, wn0, wn1;
   logic [15:0] tc0, tc1, wd0, wd1;
   logic [31:0] snap0, snap1;
   logic [3:0]  ad0, ad1;
   logic        irq0, irq1;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   snapw_cyc = -100;
   bit   mon_en = 1'b0;
   txn_t exp_q[$];
   logic [31:0] exp_snap_q[$];

   // Timer slave model
   logic [15:0] m_lo = 16'd0, m_hi = 16'd0;
   logic [31:0] m_cnt = 32'd0, m_snap = 32'd0;
   bit          m_run = 1'b0, m_cont = 1'b0, m_ito = 1'b0, m_to = 1'b0;
   bit          irq_force = 1'b0, snap_force = 1'b0;
   logic [31:0] snap_force_val = 32'd0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   wire        b_cs    = sel ? cs1 : cs0;
   wire        b_wn    = sel ? wn1 : wn0;
   wire [3:0]  b_addr  = sel ? ad1 : ad0;
   wire [15:0] b_wdata = sel ? wd1 : wd0;
   wire        b_tick  = sel ? tick1 : tick0;
   wire [15:0] b_tc    = sel ? tc1 : tc0;
   wire        b_busy  = sel ? busy1 : busy0;
   wire        b_sv    = sel ? sv1 : sv0;
   wire [31:0] b_snap  = sel ? snap1 : snap0;
   wire        irq_src = (m_to & m_ito) | irq_force;
   assign irq0 = !sel & irq_src;
   assign irq1 = sel & irq_src;

   timer_tick_master #(.PERIOD(32'h0000C34F), .CONTINUOUS(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start & !sel), .stop(stop), .cfg_period(cfg_period),
      .snap_req(snap_req), .tick(tick0), .tick_count(tc0), .busy(busy0),
      .snap_value(snap0), .snap_valid(sv0), .avm_address(ad0), .avm_chipselect(cs0),
      .avm_write_n(wn0), .avm_writedata(wd0), .avm_readdata(avm_readdata), .irq(irq0));

   timer_tick_master #(.PERIOD(32'h0000C34F), .CONTINUOUS(1'b0)) dut_os (
      .clk(clk), .reset(reset), .start(start & sel), .stop(stop), .cfg_period(cfg_period),
      .snap_req(snap_req), .tick(tick1), .tick_count(tc1), .busy(busy1),
      .snap_value(snap1), .snap_valid(sv1), .avm_address(ad1), .avm_chipselect(cs1),
      .avm_write_n(wn1), .avm_writedata(wd1), .avm_readdata(avm_readdata), .irq(irq1));

   always @(posedge clk) begin
      if (m_run) begin
         if (m_cnt == 32'd0) begin
            m_to  <= 1'b1;
            m_cnt <= {m_hi, m_lo};
            if (!m_cont) m_run <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 32'd1;
         end
      end
      if (b_cs && !b_wn) begin
         case (b_addr)
            4'd0: m_to <= 1'b0;
            4'd1: begin
               m_ito  <= b_wdata[0];
               m_cont <= b_wdata[1];
               if (b_wdata[2]) begin m_run <= 1'b1; m_cnt <= {m_hi, m_lo}; end
               if (b_wdata[3]) m_run <= 1'b0;
            end
            4'd2: begin m_lo <= b_wdata; m_run <= 1'b0; end
            4'd3: begin m_hi <= b_wdata; m_run <= 1'b0; end
            4'd4, 4'd5: m_run <= 1'b0;
            4'd6: m_snap <= snap_force ? snap_force_val : m_cnt;
            default: ;
         endcase
      end
      if (b_cs && b_wn)
         avm_readdata <= (b_addr == 4'd6) ? m_snap[15:0] :
                         (b_addr == 4'd7) ? m_snap[31:16] : 16'd0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push(input bit we, input logic [3:0] a, input logic [15:0] d, input int c);
      txn_t t;
      t.we = we; t.addr = a; t.data = d; t.cyc = c;
      exp_q.push_back(t);
   endtask

   // Scoreboard: every bus transaction, tick and snapshot is matched against expectations.
   always @(negedge clk) begin
      if (mon_en) begin
         if (b_cs) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_txn", {b_wn, 11'd0, b_addr, b_wdata}, 32'hFFFF_FFFF);
            end else begin
               txn_t e;
               e = exp_q.pop_front();
               chk("txn_kind_addr", {!b_wn, b_addr}, {e.we, e.addr});
               if (e.we) chk("txn_wdata", b_wdata, e.data);
               if (e.cyc >= 0) chk("txn_cycle", cyc, e.cyc);
               if (e.we && e.addr == 4'd6) snapw_cyc = cyc;
            end
         end
         if (b_tick || (b_cs && !b_wn && b_addr == 4'd0))
            chk("tick_with_clr", b_tick, b_cs && !b_wn && b_addr == 4'd0);
         if (b_sv) begin
            if (exp_snap_q.size() == 0) chk("unexpected_snap_valid", 1, 0);
            else chk("snap_value", b_snap, exp_snap_q.pop_front());
            chk("snap_valid_cycle", cyc, snapw_cyc + 4);
         end
      end
   end

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   // Queues the configuration writes and pulses start; n is the cycle start is accepted in.
   task automatic start_run(input logic [31:0] cfg, input logic [31:0] per,
                            input logic [15:0] ctrl, output int n);
      @(negedge clk);
      n = cyc;
      push(1, 4'd2, per[15:0], n + 1);
      push(1, 4'd3, per[31:16], n + 2);
      push(1, 4'd4, 16'd0, n + 3);
      push(1, 4'd5, 16'd0, n + 4);
      push(1, 4'd1, ctrl, n + 5);
      cfg_period = cfg;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_stop();
      push(1, 4'd1, 16'h0008, -1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_drain(20);
      @(negedge clk);
      chk("busy_after_stop", b_busy, 0);
   endtask

   initial begin
      int n;
      int w;
      repeat (3) @(negedge clk);
      chk("rst_tick", tick0, 0);
      chk("rst_tick_count", tc0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_snap", snap0, 0);
      chk("rst_snap_valid", sv0, 0);
      chk("rst_bus", {cs0, wn0, ad0, wd0}, {1'b0, 1'b1, 4'd0, 16'd0});
      reset = 1'b0;
      mon_en = 1'b1;

      // Configuration sequence and latency
      start_run(32'h0001_2345, 32'h0001_2345, 16'h0007, n);
      chk("busy_cycle1", b_busy, 1);
      wait_drain(20);
      chk("busy_in_run", b_busy, 1);
      do_stop();

      // Three timeouts of period 9
      start_run(32'd9, 32'd9, 16'h0007, n);
      for (int i = 0; i < 3; i++) push(1, 4'd0, 16'd0, -1);
      w = 0;
      while (b_tc != 16'd3 && w < 200) begin @(negedge clk); w++; end
      chk("three_ticks_reached", b_tc, 3);
      do_stop();
      chk("tick_count_after_stop", b_tc, 3);

      // Snapshot readback
      start_run(32'h0000_1000, 32'h0000_1000, 16'h0007, n);
      wait_drain(20);
      snap_force = 1'b1;
      snap_force_val = 32'h0000_00A7;
      push(1, 4'd6, 16'd0, -1);
      push(0, 4'd6, 16'd0, -1);
      push(0, 4'd7, 16'd0, -1);
      exp_snap_q.push_back(32'h0000_00A7);
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      wait_drain(20);
      repeat (4) @(negedge clk);
      chk("snap_consumed", exp_snap_q.size(), 0);
      snap_force = 1'b0;

      // stop and irq in the same RUN cycle: stop wins, no tick
      push(1, 4'd1, 16'h0008, -1);
      stop = 1'b1;
      irq_force = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      irq_force = 1'b0;
      @(negedge clk);
      chk("stop_irq_busy", b_busy, 0);
      chk("stop_irq_tick_count", b_tc, 0);
      wait_drain(5);

      // Reset during WR_P1, then a full reprogram
      @(negedge clk);
      n = cyc;
      push(1, 4'd2, 16'h1000, n + 1);
      push(1, 4'd3, 16'h0000, n + 2);
      cfg_period = 32'h0000_1000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_bus", {b_cs, b_wn, b_addr, b_wdata}, {1'b0, 1'b1, 4'd0, 16'd0});
      chk("rst_mid_tick_count", b_tc, 0);
      chk("rst_mid_busy", b_busy, 0);
      chk("rst_mid_queue", exp_q.size(), 0);
      start_run(32'h0000_1000, 32'h0000_1000, 16'h0007, n);
      wait_drain(20);
      do_stop();

      // One-shot instance with the default period
      @(negedge clk);
      sel = 1'b1;
      start_run(32'd0, 32'h0000_C34F, 16'h0005, n);
      wait_drain(20);
      push(1, 4'd0, 16'd0, -1);
      irq_force = 1'b1;
      @(negedge clk);
      irq_force = 1'b0;
      @(negedge clk);
      chk("oneshot_idle", b_busy, 0);
      chk("oneshot_tick_count", b_tc, 1);
      wait_drain(5);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
